tdm_demux8: RTL

Receive-side 1-to-8 time-division demultiplexer: the other end of the 8:1 select-driven mux path. It accepts one serial bit per qualified clock, steers each bit into the lane selected by an internal 3-bit slot counter, and presents the assembled 8-bit frame with a single-cycle valid pulse. A per-frame sync marker aligns the slot counter; misalignment is detected, flagged and recovered without software intervention.

---
 rtl/tdm_demux8.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/tdm_demux8.sv
// Receive-side 1:8 TDM demultiplexer: serial bits are steered into lanes by a sync-aligned slot counter.
// Optional even-parity ninth slot is enabled with `define TDM_DEMUX_PARITY_EN.
module tdm_demux8 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       din,
    input  logic       din_valid,
    input  logic       sync,
    output logic [7:0] dout,
    output logic       dout_valid,
    output logic [2:0] slot,
    output logic       locked,
    output logic       frame_err,
    output logic       parity_err,
    output logic [1:0] dbg_state
);

    typedef enum logic [1:0] {
        HUNT  = 2'd0,
`ifdef TDM_DEMUX_PARITY_EN
        PAR   = 2'd2,
`endif
        FRAME = 2'd1
    } state_t;

    state_t     state_q, state_d;
    logic [2:0] slot_q, slot_d;
    logic [7:0] shadow_q, shadow_d;
    logic [7:0] dout_q, dout_d;
    logic       dout_valid_q, dout_valid_d;
    logic       frame_err_q, frame_err_d;
    logic       locked_q;
`ifdef TDM_DEMUX_PARITY_EN
    logic       parity_err_q, parity_err_d;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= HUNT;
            slot_q       <= 3'd0;
            shadow_q     <= 8'h00;
            dout_q       <= 8'h00;
            dout_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            locked_q     <= 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
            parity_err_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            slot_q       <= slot_d;
            shadow_q     <= shadow_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            frame_err_q  <= frame_err_d;
            locked_q     <= (state_d != HUNT);
`ifdef TDM_DEMUX_PARITY_EN
            parity_err_q <= parity_err_d;
`endif
        end
    end

    // A sync-qualified bit always restarts the frame at slot 0, whatever state we are in.
    always_comb begin
        state_d  = state_q;
        slot_d   = slot_q;
        shadow_d = shadow_q;
        if (din_valid) begin
            case (state_q)
                HUNT: begin
                    if (sync) begin
                        shadow_d[0] = din;
                        slot_d      = 3'd1;
                        state_d     = FRAME;
                    end
                end
                FRAME: begin
                    if (sync) begin
                        shadow_d[0] = din;
                        slot_d      = 3'd1;
                    end else if (slot_q == 3'd0) begin
                        slot_d  = 3'd0;
                        state_d = HUNT;
                    end else begin
                        shadow_d[slot_q] = din;
                        slot_d           = slot_q + 3'd1;
`ifdef TDM_DEMUX_PARITY_EN
                        if (slot_q == 3'd7) state_d = PAR;
`endif
                    end
                end
`ifdef TDM_DEMUX_PARITY_EN
                PAR: begin
                    state_d = FRAME;
                    if (sync) begin
                        shadow_d[0] = din;
                        slot_d      = 3'd1;
                    end else begin
                        slot_d = 3'd0;
                    end
                end
`endif
                default: begin
                    state_d = HUNT;
                    slot_d  = 3'd0;
                end
            endcase
        end
    end

    always_comb begin
        dout_d       = dout_q;
        dout_valid_d = 1'b0;
        frame_err_d  = 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
        parity_err_d = 1'b0;
`endif
        if (din_valid) begin
            case (state_q)
                FRAME: begin
                    if (sync != (slot_q == 3'd0)) begin
                        frame_err_d = 1'b1;
                    end
`ifndef TDM_DEMUX_PARITY_EN
                    else if (!sync && slot_q == 3'd7) begin
                        dout_d       = shadow_d;
                        dout_valid_d = 1'b1;
                    end
`endif
                end
`ifdef TDM_DEMUX_PARITY_EN
                PAR: begin
                    if (sync) begin
                        frame_err_d = 1'b1;
                    end else if (^{shadow_q, din} == 1'b0) begin
                        dout_d       = shadow_q;
                        dout_valid_d = 1'b1;
                    end else begin
                        parity_err_d = 1'b1;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign slot       = slot_q;
    assign locked     = locked_q;
    assign frame_err  = frame_err_q;
    assign dbg_state  = state_q;
`ifdef TDM_DEMUX_PARITY_EN
    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule
